salsa_keystream_ctrl: RTL

- Initiator and consumer for the salsa_hash core. Latches a key, nonce, starting block position and block count from the host.
- For each block, streams the 12 input words into the core, captures the 64 serial output bytes into a local buffer, then drains them to the host over a valid/ready byte stream.
- Increments the 64-bit block position after each block and raises a one-cycle done pulse when the last block has been drained.

---
 rtl/salsa_keystream_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/salsa_keystream_ctrl.sv
// Drives salsa_hash with key/nonce/position per block, buffers the 64 output bytes and drains them as a byte stream.
// Load takes 12 cycles after core_ready; output begins the cycle after the 64th capture; ks_ready stalls only the drain.
module salsa_keystream_ctrl #(
  parameter int NBLK_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [255:0]      cfg_key,
  input  logic [63:0]       cfg_nonce,
  input  logic [63:0]       cfg_pos,
  input  logic [NBLK_W-1:0] cfg_nblocks,
  output logic              core_reset,
  output logic              core_start,
  output logic [31:0]       core_data,
  input  logic              core_ready,
  input  logic              core_writes,
  input  logic [7:0]        core_byte,
  output logic              ks_valid,
  input  logic              ks_ready,
  output logic [7:0]        ks_data,
  output logic              ks_last,
  output logic              done
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, LOAD, COLLECT, DRAIN, NEXT} state_t;

  state_t            state, state_nxt;
  logic [255:0]      key_q;
  logic [63:0]       nonce_q;
  logic [63:0]       pos_q;
  logic [NBLK_W-1:0] remaining;
  logic [3:0]        ld_idx;
  logic [3:0]        word_idx;
  logic [31:0]       word_nxt;
  logic [5:0]        wr_idx;
  logic [5:0]        rd_idx;
  logic [7:0]        ks_buf [64];
  logic              cfg_xfer;
  logic              ks_xfer;
  logic              last_blk;

  assign core_reset = ~reset_n;
  assign cfg_xfer   = cfg_valid && cfg_ready;
  assign ks_xfer    = ks_valid && ks_ready;
  assign last_blk   = (remaining == NBLK_W'(1));

  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    ks_valid  = 1'b0;
    ks_last   = 1'b0;
    ks_data   = 8'd0;
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid && (cfg_nblocks != '0)) state_nxt = WAIT_RDY;
      end
      WAIT_RDY: if (core_ready) state_nxt = LOAD;
      LOAD:     if (ld_idx == 4'd11) state_nxt = COLLECT;
      COLLECT:  if (core_writes && (wr_idx == 6'd63)) state_nxt = DRAIN;
      DRAIN: begin
        ks_valid = 1'b1;
        ks_data  = ks_buf[rd_idx];
        ks_last  = (rd_idx == 6'd63);
        if (ks_xfer && (rd_idx == 6'd63)) state_nxt = NEXT;
      end
      NEXT:     state_nxt = last_blk ? IDLE : WAIT_RDY;
      default:  state_nxt = IDLE;
    endcase
  end

  // Word presented on the next cycle: key 0..7, nonce lo/hi, position lo/hi.
  always_comb begin
    word_idx = (state == LOAD) ? ld_idx + 4'd1 : 4'd0;
    word_nxt = key_q[{word_idx[2:0], 5'd0} +: 32];
    if (word_idx[3]) begin
      case (word_idx[1:0])
        2'd0:    word_nxt = nonce_q[31:0];
        2'd1:    word_nxt = nonce_q[63:32];
        2'd2:    word_nxt = pos_q[31:0];
        default: word_nxt = pos_q[63:32];
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      core_start <= 1'b0;
      core_data  <= 32'd0;
      ld_idx     <= 4'd0;
      wr_idx     <= 6'd0;
      rd_idx     <= 6'd0;
      done       <= 1'b0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      case (state)
        IDLE: done <= cfg_xfer && (cfg_nblocks == '0);
        WAIT_RDY: begin
          if (core_ready) begin
            core_start <= 1'b1;
            core_data  <= word_nxt;
            ld_idx     <= 4'd0;
          end
        end
        LOAD: begin
          if (ld_idx == 4'd11) begin
            core_data <= 32'd0;
            wr_idx    <= 6'd0;
          end else begin
            core_data <= word_nxt;
            ld_idx    <= ld_idx + 4'd1;
          end
        end
        COLLECT: if (core_writes) wr_idx <= wr_idx + 6'd1;
        DRAIN: begin
          if (ks_xfer) begin
            rd_idx <= rd_idx + 6'd1;
            done   <= (rd_idx == 6'd63) && last_blk;
          end
        end
        default: ;
      endcase
    end
  end

  // Request fields and the byte buffer need no reset: state gates every use.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      if (cfg_xfer) begin
        key_q     <= cfg_key;
        nonce_q   <= cfg_nonce;
        pos_q     <= cfg_pos;
        remaining <= cfg_nblocks;
      end else if (state == NEXT) begin
        pos_q     <= pos_q + 64'd1;
        remaining <= remaining - NBLK_W'(1);
      end
      if ((state == COLLECT) && core_writes) ks_buf[wr_idx] <= core_byte;
    end
  end

endmodule
